// File: rtl/fifo_param_pkg.sv
// rtl/fifo_param_pkg.sv - default parameters and width helpers for fifo_param
package fifo_param_pkg;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_DEPTH     = 16;
    localparam int DEF_AF_MARGIN = 1;
    localparam int DEF_AE_MARGIN = 1;

    // Occupancy runs 0..depth inclusive, hence depth+1 states.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_param_mem.sv
// rtl/fifo_param_mem.sv - FIFO storage: synchronous write port, asynchronous read
module fifo_param_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_param.sv
// rtl/fifo_param.sv - parameterised synchronous FIFO with registered or FWFT read
module fifo_param
    import fifo_param_pkg::*;
#(
    parameter int FIFO_WIDTH = DEF_WIDTH,
    parameter int FIFO_DEPTH = DEF_DEPTH,
    parameter int AF_MARGIN  = DEF_AF_MARGIN,
    parameter int AE_MARGIN  = DEF_AE_MARGIN,
    parameter int FWFT       = 0
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [FIFO_WIDTH-1:0]                data_in,
    input  logic                                 wr_en,
    input  logic                                 rd_en,
    output logic [FIFO_WIDTH-1:0]                data_out,
    output logic                                 rd_valid,
    output logic                                 wr_ack,
    output logic                                 overflow,
    output logic                                 underflow,
    output logic                                 full,
    output logic                                 empty,
    output logic                                 almostfull,
    output logic                                 almostempty,
    output logic [count_width(FIFO_DEPTH)-1:0]   count
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = count_width(FIFO_DEPTH);

    if (FIFO_WIDTH < 1 || FIFO_WIDTH > 64) begin : g_bad_width
        $error("fifo_param: FIFO_WIDTH must be 1..64");
    end
    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 1024) begin : g_bad_depth
        $error("fifo_param: FIFO_DEPTH must be 2..1024");
    end
    if (AF_MARGIN < 1 || AF_MARGIN > FIFO_DEPTH - 1) begin : g_bad_af
        $error("fifo_param: AF_MARGIN must be 1..FIFO_DEPTH-1");
    end
    if (AE_MARGIN < 1 || AE_MARGIN > FIFO_DEPTH - 1) begin : g_bad_ae
        $error("fifo_param: AE_MARGIN must be 1..FIFO_DEPTH-1");
    end
    if (FWFT != 0 && FWFT != 1) begin : g_bad_fwft
        $error("fifo_param: FWFT must be 0 or 1");
    end

    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [FIFO_WIDTH-1:0] mem_rdata;
    logic                  wr_accept;
    logic                  rd_accept;

    assign full        = (count == CW'(FIFO_DEPTH));
    assign empty       = (count == '0);
    assign almostfull  = (count >= CW'(FIFO_DEPTH - AF_MARGIN)) && (count < CW'(FIFO_DEPTH));
    assign almostempty = (count != '0) && (count <= CW'(AE_MARGIN));

    // Acceptance looks only at the current flags, so a simultaneous read never frees room for a write.
    assign wr_accept = wr_en && !full;
    assign rd_accept = rd_en && !empty;

    fifo_param_mem #(
        .WIDTH (FIFO_WIDTH),
        .DEPTH (FIFO_DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_accept),
        .waddr (wr_ptr),
        .wdata (data_in),
        .raddr (rd_ptr),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            wr_ack    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            wr_ack    <= wr_accept;
            overflow  <= wr_en && full;
            underflow <= rd_en && empty;
            if (wr_accept) begin
                wr_ptr <= (wr_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (rd_accept) begin
                rd_ptr <= (rd_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({wr_accept, rd_accept})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    if (FWFT != 0) begin : g_fwft
        // Head word is exposed directly; zero while nothing is stored.
        assign data_out = empty ? '0 : mem_rdata;
        assign rd_valid = !empty;
    end else begin : g_reg
        logic [FIFO_WIDTH-1:0] dout_q;
        logic                  valid_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                dout_q  <= '0;
                valid_q <= 1'b0;
            end else begin
                valid_q <= rd_accept;
                if (rd_accept) begin
                    dout_q <= mem_rdata;
                end
            end
        end

        assign data_out = dout_q;
        assign rd_valid = valid_q;
    end

endmodule

// File: tb/tb_fifo_param.sv
// tb/tb_fifo_param.sv - directed self-checking bench for fifo_param
module tb_fifo_param;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    // a: defaults, registered read
    logic [7:0] a_din, a_dout;
    logic       a_wr, a_rd, a_rv, a_ack, a_ov, a_un, a_full, a_empty, a_af, a_ae;
    logic [4:0] a_count;
    // b: depth 5, registered read
    logic [7:0] b_din, b_dout;
    logic       b_wr, b_rd, b_rv, b_ack, b_ov, b_un, b_full, b_empty, b_af, b_ae;
    logic [2:0] b_count;
    // c: defaults, first-word-fall-through
    logic [7:0] c_din, c_dout;
    logic       c_wr, c_rd, c_rv, c_ack, c_ov, c_un, c_full, c_empty, c_af, c_ae;
    logic [4:0] c_count;

    int checks   = 0;
    int failures = 0;
    int exp_rd;

    fifo_param u_a (
        .clk(clk), .rst_n(rst_n), .data_in(a_din), .wr_en(a_wr), .rd_en(a_rd),
        .data_out(a_dout), .rd_valid(a_rv), .wr_ack(a_ack), .overflow(a_ov),
        .underflow(a_un), .full(a_full), .empty(a_empty), .almostfull(a_af),
        .almostempty(a_ae), .count(a_count)
    );

    fifo_param #(.FIFO_DEPTH(5)) u_b (
        .clk(clk), .rst_n(rst_n), .data_in(b_din), .wr_en(b_wr), .rd_en(b_rd),
        .data_out(b_dout), .rd_valid(b_rv), .wr_ack(b_ack), .overflow(b_ov),
        .underflow(b_un), .full(b_full), .empty(b_empty), .almostfull(b_af),
        .almostempty(b_ae), .count(b_count)
    );

    fifo_param #(.FWFT(1)) u_c (
        .clk(clk), .rst_n(rst_n), .data_in(c_din), .wr_en(c_wr), .rd_en(c_rd),
        .data_out(c_dout), .rd_valid(c_rv), .wr_ack(c_ack), .overflow(c_ov),
        .underflow(c_un), .full(c_full), .empty(c_empty), .almostfull(c_af),
        .almostempty(c_ae), .count(c_count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        a_din = '0; a_wr = 1'b0; a_rd = 1'b0;
        b_din = '0; b_wr = 1'b0; b_rd = 1'b0;
        c_din = '0; c_wr = 1'b0; c_rd = 1'b0;
        step();
        step();

        check("rst_count", a_count, 0);
        check("rst_empty", a_empty, 1);
        check("rst_full", a_full, 0);
        check("rst_af", a_af, 0);
        check("rst_ae", a_ae, 0);
        check("rst_dout", a_dout, 0);
        check("rst_rv", a_rv, 0);
        check("rst_ack", a_ack, 0);
        check("rst_ov", a_ov, 0);
        check("rst_un", a_un, 0);
        check("rst_c_dout", c_dout, 0);
        check("rst_c_rv", c_rv, 0);
        rst_n = 1'b1;

        // Fill the default FIFO with 0x00..0x0F
        for (int i = 0; i < 16; i++) begin
            a_din = 8'(i);
            a_wr  = 1'b1;
            step();
            check("fill_ack", a_ack, 1);
            check("fill_count", a_count, i + 1);
            check("fill_af", a_af, (i + 1 == 15) ? 1 : 0);
            check("fill_full", a_full, (i + 1 == 16) ? 1 : 0);
        end
        a_wr = 1'b0;
        step();
        check("fill_ack_idle", a_ack, 0);
        check("fill_count_idle", a_count, 16);

        // Full: write rejected, read accepted in the same cycle
        a_din = 8'hFF; a_wr = 1'b1; a_rd = 1'b1;
        step();
        a_wr = 1'b0; a_rd = 1'b0;
        check("full_rw_ov", a_ov, 1);
        check("full_rw_ack", a_ack, 0);
        check("full_rw_count", a_count, 15);
        check("full_rw_dout", a_dout, 8'h00);
        check("full_rw_rv", a_rv, 1);
        step();
        check("full_rw_ov_clr", a_ov, 0);
        check("full_rw_rv_clr", a_rv, 0);
        check("full_rw_dout_hold", a_dout, 8'h00);

        a_rd = 1'b1;
        for (int i = 1; i < 16; i++) begin
            step();
            check("drain_dout", a_dout, i);
            check("drain_rv", a_rv, 1);
        end
        a_rd = 1'b0;
        check("drain_empty", a_empty, 1);

        // Empty: read rejected, write accepted in the same cycle
        a_din = 8'hA5; a_wr = 1'b1; a_rd = 1'b1;
        step();
        a_wr = 1'b0; a_rd = 1'b0;
        check("empty_rw_un", a_un, 1);
        check("empty_rw_count", a_count, 1);
        check("empty_rw_dout", a_dout, 8'h0F);
        check("empty_rw_rv", a_rv, 0);
        check("empty_rw_ae", a_ae, 1);
        a_rd = 1'b1;
        step();
        a_rd = 1'b0;
        check("empty_rw_read", a_dout, 8'hA5);
        check("empty_rw_read_rv", a_rv, 1);
        check("empty_rw_read_un", a_un, 0);
        check("empty_rw_read_empty", a_empty, 1);

        // Depth 5: 40 writes with reads trailing by two, wrapping 8 times
        exp_rd = 0;
        for (int i = 0; i < 40; i++) begin
            b_din = 8'(i);
            b_wr  = 1'b1;
            b_rd  = (i >= 2);
            step();
            check("d5_count", b_count, (i == 0) ? 1 : 2);
            check("d5_ov", b_ov, 0);
            check("d5_un", b_un, 0);
            check("d5_full", b_full, 0);
            check("d5_rv", b_rv, (i >= 2) ? 1 : 0);
            if (i >= 2) begin
                check("d5_dout", b_dout, exp_rd);
                exp_rd++;
            end
        end
        b_wr = 1'b0;
        b_rd = 1'b1;
        step();
        check("d5_tail0", b_dout, 38);
        check("d5_tail0_ae", b_ae, 1);
        step();
        b_rd = 1'b0;
        check("d5_tail1", b_dout, 39);
        check("d5_tail_empty", b_empty, 1);

        // First-word-fall-through
        c_din = 8'h11; c_wr = 1'b1;
        step();
        c_din = 8'h22;
        check("fwft_first", c_dout, 8'h11);
        check("fwft_first_rv", c_rv, 1);
        check("fwft_first_ack", c_ack, 1);
        step();
        c_wr = 1'b0;
        check("fwft_hold", c_dout, 8'h11);
        check("fwft_count2", c_count, 2);
        c_rd = 1'b1;
        step();
        c_rd = 1'b0;
        check("fwft_pop1", c_dout, 8'h22);
        check("fwft_pop1_rv", c_rv, 1);
        c_rd = 1'b1;
        step();
        c_rd = 1'b0;
        check("fwft_pop2_empty", c_empty, 1);
        check("fwft_pop2_rv", c_rv, 0);
        check("fwft_pop2_dout", c_dout, 0);
        check("fwft_pop2_flags", {c_full, c_af, c_ae, c_ov, c_un}, 0);

        // Asynchronous reset in the middle of a write burst
        for (int i = 0; i < 7; i++) begin
            a_din = 8'(8'h30 + i);
            a_wr  = 1'b1;
            step();
        end
        check("burst_count", a_count, 7);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_count", a_count, 0);
        check("arst_empty", a_empty, 1);
        check("arst_full", a_full, 0);
        check("arst_af", a_af, 0);
        check("arst_ae", a_ae, 0);
        check("arst_dout", a_dout, 0);
        check("arst_rv", a_rv, 0);
        check("arst_ack", a_ack, 0);
        check("arst_ov", a_ov, 0);
        check("arst_un", a_un, 0);
        a_wr = 1'b0;
        step();
        rst_n = 1'b1;
        a_rd  = 1'b1;
        step();
        a_rd = 1'b0;
        check("arst_read_un", a_un, 1);
        check("arst_read_dout", a_dout, 0);
        check("arst_read_rv", a_rv, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
